iq_window_gen: RTL
==================

# iq_window_gen

Windowed I/Q test-sample transmitter for the square-adder energy path. On each `start` it emits a one-cycle window clear for the downstream accumulator, then streams exactly `WIN_LEN` I/Q sample pairs over a valid/ready handshake with start- and end-of-window markers. It replaces the free-running sample counter on the bench and board test tops, so that accumulator results are deterministic and self-checkable.

## Interface
- `DATA_W`, 8: width of each of I and Q, unsigned.
- `WIN_LEN`, 16: beats per window, 1..65535.
- `ACC_W`, 30: reference energy width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `aclr_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request for a window; honoured only in IDLE.
- `mode`  in  2  pattern select; sampled on an accepted `start`.
- `seed`  in  DATA_W  pattern seed; sampled on an accepted `start`.
- `win_clr`  out  1  one-cycle clear pulse to the downstream accumulator.
- `out_valid`  out  1  sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_real`, `out_imag`  out  DATA_W  sample pair.
- `out_sof`, `out_eof`  out  1  qualify beat 0 and beat `WIN_LEN-1`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.
- `ref_energy`  out  ACC_W  golden sum of squares for the window.

## Operation
- FSM states: IDLE, CLEAR, STREAM, DONE.
  - IDLE → CLEAR on `start`.
  - CLEAR → STREAM unconditionally.
  - STREAM → DONE when the beat with k = `WIN_LEN-1` is accepted.
  - DONE → IDLE unconditionally.
- `start` outside IDLE is ignored. This includes the DONE cycle.
- Beat index k counts from 0 and advances only on an accepted beat (`out_valid && out_ready`).
- Patterns. All arithmetic is mod 2^`DATA_W`.
  - 0, ramp: real = seed + k, imag = seed − k.
  - 1, constant: real = imag = seed.
  - 2, LFSR: 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded with {seed, ~seed} in CLEAR. real = lfsr[7:0], imag = lfsr[15:8]. The LFSR steps on each accepted beat. The load value is never zero. With `DATA_W` ≠ 8 the LFSR is zero-extended or truncated to fit.
  - 3, alternate: real = seed on even k and ~seed on odd k; imag = 0.
- Handshake rules:
  - While `out_valid` is high and `out_ready` is low, `out_real`, `out_imag`, `out_sof` and `out_eof` hold stable.
  - `out_valid` never drops before acceptance.
  - `out_ready` has no combinational path to any output.
- With `WIN_LEN` = 1, `out_sof` and `out_eof` assert on the same beat.
- `ref_energy`:
  - Cleared in CLEAR.
  - On each accepted beat, adds real² + imag², wrapping mod 2^`ACC_W`.
  - Stable from the `done` cycle until the next CLEAR.
- Reset: every output is 0 and the state is IDLE.
  - Applies immediately on `aclr_n` low.
  - Reset mid-window abandons the stream; no `done` pulse is produced.

## Timing
- `start` sampled high at cycle t (in IDLE):
  - CLEAR with `win_clr` = 1 at t+1.
  - `out_valid` = 1 with beat 0 at t+2.
- With `out_ready` held high, the last beat is at t+1+`WIN_LEN` and `done` is at t+2+`WIN_LEN`.
- Each ready-low cycle during STREAM delays `done` by one cycle.
- `busy` is high from t+1 through the `done` cycle inclusive.
- `out_valid` is low outside STREAM. `win_clr` is high only in CLEAR.

## Configuration
- `IQ_REF_ENERGY_EN` defined:
  - The `ref_energy` accumulator and its squarers are built.
  - Intended for bench and self-check tops.
- Not defined:
  - `ref_energy` is tied to 0 and no multipliers are inferred.
  - Streaming behaviour is unchanged; the port list is identical.

## Structure
- Package `iq_gen_pkg` holds:
  - the state enum;
  - mode constants (MODE_RAMP, MODE_CONST, MODE_LFSR, MODE_ALT);
  - the LFSR tap mask and width constant;
  - the default `DATA_W`/`ACC_W` values.
- One sub-module, `iq_lfsr16`, with ports: load, load value, step enable, state out.
- FSM, beat counter, pattern mux and energy accumulator live in the top module.

## Test plan
- Ramp, seed 8'h10, `WIN_LEN` 16, ready always 1:
  - real = 10..1F, imag = 10,0F..01.
  - sof on beat 0, eof on beat 15.
  - `done` at t+18.
  - `ref_energy` = 30'h29B0 (10672).
- Constant, seed 8'hFF, `WIN_LEN` 16: every beat FF/FF; `ref_energy` = 30'h1FC020.
- Ramp, `out_ready` toggling 1,0 each cycle:
  - exactly 16 accepted beats, no duplicates or gaps;
  - data stable across stalls;
  - `done` one cycle after the 16th acceptance.
- `start` pulsed during CLEAR, STREAM and DONE: ignored; no second `win_clr`; the window is unaffected.
- LFSR, seed 8'h00: first beat real = FF, imag = 00; no all-zero LFSR state within 1000 beats.
- `aclr_n` low at beat 5:
  - all outputs 0 at once, no `done`;
  - a following `start` yields a full window beginning with `out_sof` and a correct `ref_energy`.

Source files
------------

// File: rtl/iq_gen_pkg.sv
// Shared types and constants for the windowed I/Q test-sample generator.
// Holds the FSM encoding, pattern selects, LFSR definition and default widths.
package iq_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } iq_state_e;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_CONST = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_ALT   = 2'd3;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 30;
    localparam int DEF_WIN_LEN = 16;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/iq_window_gen_if.sv
// I/Q sample stream: valid/ready handshake carrying one real/imag pair per beat
// with start- and end-of-window qualifiers.
interface iq_window_gen_if
    import iq_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_imag;
    logic              out_sof;
    logic              out_eof;

    modport master (
        output out_valid,
        output out_real,
        output out_imag,
        output out_sof,
        output out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_real,
        input  out_imag,
        input  out_sof,
        input  out_eof,
        output out_ready
    );
endinterface

// File: rtl/iq_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step enable.
// Latency: state updates on the clock after load/step; load wins over step.
// Backpressure: none; the caller only asserts step on an accepted beat.
module iq_lfsr16
    import iq_gen_pkg::*;
(
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/iq_window_gen.sv
// Windowed I/Q source: one win_clr pulse, then WIN_LEN patterned beats with sof/eof, then done.
// Latency: win_clr 1 cycle after start, beat 0 after 2; done 1 cycle after the last acceptance.
// Backpressure: out_ready low holds the beat stable; IQ_REF_ENERGY_EN builds ref_energy, else 0.
module iq_window_gen
    import iq_gen_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              win_clr,
    iq_window_gen_if.master   stream,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  ref_energy
);

    localparam logic [15:0] LAST_K = 16'(WIN_LEN - 1);

    iq_state_e         state;
    iq_state_e         state_nxt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] seed_q;
    logic [15:0]       beat_k;
    logic [7:0]        seed8;
    logic [LFSR_W-1:0] lfsr_ld;
    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_load;
    logic              streaming;
    logic              accept;
    logic              last_beat;
    logic              start_ok;
    logic [DATA_W-1:0] k_d;
    logic [DATA_W-1:0] pat_real;
    logic [DATA_W-1:0] pat_imag;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every control output is a pure decode of the registered state, so
    // out_ready only ever steers state_nxt.
    always_comb begin
        state_nxt = state;
        win_clr   = 1'b0;
        streaming = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                win_clr   = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                streaming = 1'b1;
                if (stream.out_ready && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign start_ok  = (state == ST_IDLE) && start;
    assign accept    = streaming && stream.out_ready;
    assign last_beat = (beat_k == LAST_K);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mode_q <= MODE_RAMP;
            seed_q <= '0;
            beat_k <= '0;
        end else if (start_ok) begin
            mode_q <= mode;
            seed_q <= seed;
            beat_k <= '0;
        end else if (accept) begin
            beat_k <= beat_k + 16'd1;
        end
    end

    // Load value {seed, ~seed} can never be all zeros, so the LFSR cannot lock up.
    assign seed8     = 8'(seed_q);
    assign lfsr_ld   = {seed8, ~seed8};
    assign lfsr_load = (state == ST_CLEAR);

    iq_lfsr16 u_lfsr (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .load     (lfsr_load),
        .load_val (lfsr_ld),
        .step     (accept),
        .state    (lfsr_q)
    );

    assign k_d = DATA_W'(beat_k);

    always_comb begin
        pat_real = seed_q;
        pat_imag = seed_q;
        case (mode_q)
            MODE_RAMP: begin
                pat_real = seed_q + k_d;
                pat_imag = seed_q - k_d;
            end
            MODE_CONST: begin
                pat_real = seed_q;
                pat_imag = seed_q;
            end
            MODE_LFSR: begin
                pat_real = DATA_W'(lfsr_q[7:0]);
                pat_imag = DATA_W'(lfsr_q[15:8]);
            end
            MODE_ALT: begin
                pat_real = beat_k[0] ? ~seed_q : seed_q;
                pat_imag = '0;
            end
            default: begin
                pat_real = '0;
                pat_imag = '0;
            end
        endcase
    end

    assign stream.out_valid = streaming;
    assign stream.out_real  = streaming ? pat_real : '0;
    assign stream.out_imag  = streaming ? pat_imag : '0;
    assign stream.out_sof   = streaming && (beat_k == 16'd0);
    assign stream.out_eof   = streaming && last_beat;

`ifdef IQ_REF_ENERGY_EN
    localparam int SQ_W = 2 * DATA_W + 1;

    logic [SQ_W-1:0]  re_x;
    logic [SQ_W-1:0]  im_x;
    logic [SQ_W-1:0]  beat_sq;
    logic [ACC_W-1:0] acc_q;

    assign re_x    = SQ_W'(pat_real);
    assign im_x    = SQ_W'(pat_imag);
    assign beat_sq = re_x * re_x + im_x * im_x;

    // Cleared as the window is launched, so it already reads 0 in the CLEAR cycle.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            acc_q <= '0;
        end else if (start_ok) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_q + ACC_W'(beat_sq);
        end
    end

    assign ref_energy = acc_q;
`else
    assign ref_energy = '0;
`endif

endmodule
